stage2_bus_decoder: RTL and testbench

STAGE2_BUS_DECODER -- requirements
Module: stage2_bus_decoder

---
 rtl/stage2_bus_decoder_if.sv | 32 +++
 rtl/stage2_bus_decoder.sv | 179 +++++++++++++++++
 tb/tb_stage2_bus_decoder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stage2_bus_decoder_if.sv
// Bus-side signal bundle for the stage-2 bus decoder.
// The master modport is the pipeline/arbiter side; the slave modport is the decoder.
interface stage2_bus_decoder_if;
  logic [3:0]  MainAssert;
  logic [3:0]  MainLoad;
  logic [1:0]  Inc;
  logic [2:0]  Addr;
  logic        BusRequest;
  logic        PCRA_Flip;
  logic        Break;
  logic        BusGrant;
  logic [7:0]  DataBusIn;
  logic [7:0]  DataBusOut;
  logic        DataBusDrive;
  logic [15:0] AddrBus;
  logic        AddrValid;
  logic        BusAck;
  logic        Stall;
  logic        Halted;

  modport master (
    output MainAssert, MainLoad, Inc, Addr, BusRequest, PCRA_Flip, Break,
           BusGrant, DataBusIn,
    input  DataBusOut, DataBusDrive, AddrBus, AddrValid, BusAck, Stall, Halted
  );

  modport slave (
    input  MainAssert, MainLoad, Inc, Addr, BusRequest, PCRA_Flip, Break,
           BusGrant, DataBusIn,
    output DataBusOut, DataBusDrive, AddrBus, AddrValid, BusAck, Stall, Halted
  );
endinterface

// File: rtl/stage2_bus_decoder.sv
// Stage-2 bus decoder: register file with a shared 8-bit data bus, a 16-bit
// address mux, PC/SP increment logic, a PC/RA swap bit, a sticky halt flag and
// a three-state bus-ownership FSM that freezes the datapath while an external
// master is requesting or owning the bus.
// Reset_n asserts asynchronously; its release is expected to be synchronous
// to ClockIn from upstream, so no local synchronizer is added.
module stage2_bus_decoder (
  input  logic                 ClockIn,
  input  logic                 Reset_n,
  stage2_bus_decoder_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_OWNED = 2'd2
  } bus_state_e;

  bus_state_e  state, state_n;
  logic        stall_q, ack_q;

  logic [7:0]  reg_a, reg_b, reg_c, reg_d;
  logic [15:0] sp, si, di, pc0, pc1;
  logic        pc_sel, halted;

  logic [15:0] act_pc, ra;
  logic [7:0]  sel_byte;
  logic        sel_hit, drive;
  logic [7:0]  bus_val;
  logic [15:0] addr_mux;
  logic        addr_hit;
  logic        upd_en, inc_pc;
  logic [3:0]  ml;
  logic [15:0] sp_n, si_n, di_n, pc0_n, pc1_n;

  // Increment/decrement a 16-bit register, then let a byte load override it.
  // The load merges with the pre-cycle value, so a colliding increment is lost.
  function automatic logic [15:0] next16(input logic [15:0] cur,
                                         input logic        up,
                                         input logic        down,
                                         input logic        ld_lo,
                                         input logic        ld_hi,
                                         input logic [7:0]  b);
    logic [15:0] r;
    r = cur;
    if (up)        r = cur + 16'd1;
    else if (down) r = cur - 16'd1;
    if (ld_lo)      r = {cur[15:8], b};
    else if (ld_hi) r = {b, cur[7:0]};
    return r;
  endfunction

  assign act_pc = pc_sel ? pc1 : pc0;
  assign ra     = pc_sel ? pc0 : pc1;
  assign ml     = bus.MainLoad;

  // Datapath only moves while nobody else is involved with the bus.
  assign upd_en = (state == ST_IDLE);
  assign inc_pc = (bus.Inc == 2'd1) && !halted;

  // Source byte select for the data bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_byte = 8'h00;
    sel_hit  = 1'b1;
    case (bus.MainAssert)
      4'd1:    sel_byte = reg_a;
      4'd2:    sel_byte = reg_b;
      4'd3:    sel_byte = reg_c;
      4'd4:    sel_byte = reg_d;
      4'd5:    sel_byte = sp[7:0];
      4'd6:    sel_byte = sp[15:8];
      4'd7:    sel_byte = si[7:0];
      4'd8:    sel_byte = si[15:8];
      4'd9:    sel_byte = di[7:0];
      4'd10:   sel_byte = di[15:8];
      4'd11:   sel_byte = act_pc[7:0];
      4'd12:   sel_byte = act_pc[15:8];
      4'd13:   sel_byte = ra[7:0];
      4'd14:   sel_byte = ra[15:8];
      default: sel_hit  = 1'b0;
    endcase
  end

  assign drive            = sel_hit && (state != ST_OWNED);
  assign bus_val          = drive ? sel_byte : bus.DataBusIn;
  assign bus.DataBusOut   = bus_val;
  assign bus.DataBusDrive = drive;

  // Address source select; unused codes give a zero, invalid address.
  always_comb begin
    addr_mux = 16'h0000;
    addr_hit = 1'b1;
    case (bus.Addr)
      3'd0:    addr_mux = act_pc;
      3'd1:    addr_mux = sp;
      3'd2:    addr_mux = si;
      3'd3:    addr_mux = di;
      3'd4:    addr_mux = {reg_c, reg_d};
      3'd5:    addr_mux = ra;
      default: addr_hit = 1'b0;
    endcase
  end

  assign bus.AddrBus   = addr_mux;
  assign bus.AddrValid = addr_hit && (state != ST_OWNED);

  // Next values of the 16-bit registers; PC targets follow the pre-toggle PcSel.
  always_comb begin
    sp_n  = next16(sp, bus.Inc == 2'd2, bus.Inc == 2'd3, ml == 4'd5, ml == 4'd6, bus_val);
    si_n  = next16(si, 1'b0, 1'b0, ml == 4'd7, ml == 4'd8, bus_val);
    di_n  = next16(di, 1'b0, 1'b0, ml == 4'd9, ml == 4'd10, bus_val);
    pc0_n = next16(pc0, inc_pc && !pc_sel, 1'b0,
                   (ml == 4'd11 && !pc_sel) || (ml == 4'd13 && pc_sel),
                   (ml == 4'd12 && !pc_sel) || (ml == 4'd14 && pc_sel), bus_val);
    pc1_n = next16(pc1, inc_pc && pc_sel, 1'b0,
                   (ml == 4'd11 && pc_sel) || (ml == 4'd13 && !pc_sel),
                   (ml == 4'd12 && pc_sel) || (ml == 4'd14 && !pc_sel), bus_val);
  end

  // Bus ownership next-state; BusGrant is ignored in IDLE so REQ always lasts a cycle.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (bus.BusRequest) state_n = ST_REQ;
      ST_REQ:   if (bus.BusGrant)   state_n = ST_OWNED;
      ST_OWNED: if (!bus.BusGrant)  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // State register plus registered Stall/BusAck decoded from the next state.
  always_ff @(posedge ClockIn or negedge Reset_n) begin
    // NOTE: sequential state is written with non-blocking assignments so all flops update together.
    if (!Reset_n) begin
      state   <= ST_IDLE;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state   <= state_n;
      stall_q <= (state_n != ST_IDLE);
      ack_q   <= (state_n == ST_OWNED);
    end
  end

  assign bus.Stall  = stall_q;
  assign bus.BusAck = ack_q;
  assign bus.Halted = halted;

  // Register file, PC/RA swap and sticky halt; frozen outside IDLE.
  always_ff @(posedge ClockIn or negedge Reset_n) begin
    if (!Reset_n) begin
      reg_a  <= 8'h00;
      reg_b  <= 8'h00;
      reg_c  <= 8'h00;
      reg_d  <= 8'h00;
      sp     <= 16'h0000;
      si     <= 16'h0000;
      di     <= 16'h0000;
      pc0    <= 16'h0000;
      pc1    <= 16'h0000;
      pc_sel <= 1'b0;
      halted <= 1'b0;
    end else if (upd_en) begin
      if (ml == 4'd1) reg_a <= bus_val;
      if (ml == 4'd2) reg_b <= bus_val;
      if (ml == 4'd3) reg_c <= bus_val;
      if (ml == 4'd4) reg_d <= bus_val;
      sp     <= sp_n;
      si     <= si_n;
      di     <= di_n;
      pc0    <= pc0_n;
      pc1    <= pc1_n;
      pc_sel <= pc_sel ^ bus.PCRA_Flip;
      halted <= halted | bus.Break;
    end
  end

endmodule

// File: tb/tb_stage2_bus_decoder.sv
// Self-checking bench for stage2_bus_decoder. Expected values are queued as
// stimulus is applied and popped against the DUT outputs when they are sampled.
module tb_stage2_bus_decoder;

  logic ClockIn = 1'b0;
  logic Reset_n;

  stage2_bus_decoder_if bus ();

  stage2_bus_decoder dut (
    .ClockIn (ClockIn),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #20 ClockIn = ~ClockIn;

  localparam int SEL_DOUT  = 0;
  localparam int SEL_DRIVE = 1;
  localparam int SEL_ADDR  = 2;
  localparam int SEL_AVAL  = 3;
  localparam int SEL_STALL = 4;
  localparam int SEL_ACK   = 5;
  localparam int SEL_HALT  = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SEL_DOUT:  return {8'h00, bus.DataBusOut};
      SEL_DRIVE: return {15'h0, bus.DataBusDrive};
      SEL_ADDR:  return bus.AddrBus;
      SEL_AVAL:  return {15'h0, bus.AddrValid};
      SEL_STALL: return {15'h0, bus.Stall};
      SEL_ACK:   return {15'h0, bus.BusAck};
      SEL_HALT:  return {15'h0, bus.Halted};
      default:   return 16'hxxxx;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic drive_idle();
    bus.MainAssert = 4'd0;
    bus.MainLoad   = 4'd0;
    bus.Inc        = 2'd0;
    bus.Addr       = 3'd0;
    bus.BusRequest = 1'b0;
    bus.PCRA_Flip  = 1'b0;
    bus.Break      = 1'b0;
  endtask

  // One clocked operation: apply inputs, check anything queued for this cycle,
  // take the edge, then return the per-cycle controls to idle.
  task automatic step(input logic [3:0] ma, input logic [3:0] ml, input logic [1:0] inc,
                      input logic br, input logic fl, input logic bk, input logic [7:0] din);
    bus.MainAssert = ma;
    bus.MainLoad   = ml;
    bus.Inc        = inc;
    bus.BusRequest = br;
    bus.PCRA_Flip  = fl;
    bus.Break      = bk;
    bus.DataBusIn  = din;
    #1;
    drain();
    @(posedge ClockIn);
    #2;
    drive_idle();
  endtask

  task automatic rd_reg(input string tag, input logic [3:0] code, input logic [7:0] v,
                        input logic drv);
    bus.MainAssert = code;
    #1;
    push_exp({tag, ".dout"}, SEL_DOUT, {8'h00, v});
    push_exp({tag, ".drv"}, SEL_DRIVE, {15'h0, drv});
    drain();
    bus.MainAssert = 4'd0;
  endtask

  task automatic rd_addr(input string tag, input logic [2:0] code, input logic [15:0] v,
                         input logic vld);
    bus.Addr = code;
    #1;
    push_exp({tag, ".addr"}, SEL_ADDR, v);
    push_exp({tag, ".aval"}, SEL_AVAL, {15'h0, vld});
    drain();
    bus.Addr = 3'd0;
  endtask

  task automatic chk_status(input string tag, input logic st, input logic ack, input logic hlt);
    push_exp({tag, ".stall"}, SEL_STALL, {15'h0, st});
    push_exp({tag, ".ack"}, SEL_ACK, {15'h0, ack});
    push_exp({tag, ".halt"}, SEL_HALT, {15'h0, hlt});
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset_n       = 1'b0;
    bus.BusGrant  = 1'b0;
    bus.DataBusIn = 8'h3C;
    drive_idle();
    #5;

    // Reset state
    chk_status("rst", 1'b0, 1'b0, 1'b0);
    rd_reg("rst_none", 4'd0, 8'h3C, 1'b0);
    rd_reg("rst_a", 4'd1, 8'h00, 1'b1);
    rd_addr("rst_pc", 3'd0, 16'h0000, 1'b1);
    rd_addr("rst_code6", 3'd6, 16'h0000, 1'b0);
    @(negedge ClockIn);
    Reset_n = 1'b1;

    // Bus transfer A <- DataBusIn, then B <- A
    step(4'd0, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h5A);
    push_exp("mv_a_b.drv", SEL_DRIVE, 16'h0001);
    push_exp("mv_a_b.dout", SEL_DOUT, 16'h005A);
    step(4'd1, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_reg("b_after_mv", 4'd2, 8'h5A, 1'b1);
    rd_reg("a_after_mv", 4'd1, 8'h5A, 1'b1);
    // Same code on both fields is a no-op even with foreign data on DataBusIn
    step(4'd1, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
    rd_reg("a_selfload", 4'd1, 8'h5A, 1'b1);
    bus.DataBusIn = 8'hC3;
    rd_reg("code15", 4'd15, 8'hC3, 1'b0);

    // SP wraparound and byte loads
    step(4'd0, 4'd0, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_addr("sp_dec_wrap", 3'd1, 16'hFFFF, 1'b1);
    rd_reg("sp_hi", 4'd6, 8'hFF, 1'b1);
    step(4'd0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_addr("sp_inc_wrap", 3'd1, 16'h0000, 1'b1);
    step(4'd0, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, 8'h34);
    step(4'd0, 4'd6, 2'd0, 1'b0, 1'b0, 1'b0, 8'h12);
    rd_addr("sp_load", 3'd1, 16'h1234, 1'b1);
    step(4'd0, 4'd5, 2'd0, 1'b0, 1'b0, 1'b0, 8'hFF);
    // Load hi + Inc on SP together: increment lost, low byte keeps FF
    step(4'd0, 4'd6, 2'd2, 1'b0, 1'b0, 1'b0, 8'hAB);
    rd_addr("sp_ld_inc", 3'd1, 16'hABFF, 1'b1);

    // PC0/PC1 setup, flip with increment
    step(4'd0, 4'd11, 2'd0, 1'b0, 1'b0, 1'b0, 8'h34);
    step(4'd0, 4'd12, 2'd0, 1'b0, 1'b0, 1'b0, 8'h12);
    step(4'd0, 4'd13, 2'd0, 1'b0, 1'b0, 1'b0, 8'hCD);
    step(4'd0, 4'd14, 2'd0, 1'b0, 1'b0, 1'b0, 8'hAB);
    rd_addr("pc0_init", 3'd0, 16'h1234, 1'b1);
    rd_addr("ra_init", 3'd5, 16'hABCD, 1'b1);
    step(4'd0, 4'd0, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00);
    rd_addr("pc_after_flip", 3'd0, 16'hABCD, 1'b1);
    rd_addr("ra_after_flip", 3'd5, 16'h1235, 1'b1);
    rd_reg("pc_lo_byte", 4'd11, 8'hCD, 1'b1);
    rd_reg("ra_hi_byte", 4'd14, 8'h12, 1'b1);

    // C, D, SI, DI
    step(4'd0, 4'd3, 2'd0, 1'b0, 1'b0, 1'b0, 8'hDE);
    step(4'd0, 4'd4, 2'd0, 1'b0, 1'b0, 1'b0, 8'hAD);
    step(4'd0, 4'd7, 2'd0, 1'b0, 1'b0, 1'b0, 8'h78);
    step(4'd0, 4'd10, 2'd0, 1'b0, 1'b0, 1'b0, 8'h9A);
    rd_addr("cd_pair", 3'd4, 16'hDEAD, 1'b1);
    rd_addr("si", 3'd2, 16'h0078, 1'b1);
    rd_addr("di", 3'd3, 16'h9A00, 1'b1);

    // Bus request, grant two cycles later, release
    push_exp("req_pre.stall", SEL_STALL, 16'h0000);
    step(4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk_status("req1", 1'b1, 1'b0, 1'b0);
    step(4'd0, 4'd1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h00);
    chk_status("req2", 1'b1, 1'b0, 1'b0);
    bus.BusGrant = 1'b1;
    step(4'd0, 4'd1, 2'd2, 1'b0, 1'b0, 1'b0, 8'h66);
    chk_status("owned", 1'b1, 1'b1, 1'b0);
    rd_reg("owned_nodrive", 4'd1, 8'h66, 1'b0);
    rd_addr("owned_addr", 3'd0, 16'hABCD, 1'b0);
    step(4'd0, 4'd2, 2'd0, 1'b0, 1'b0, 1'b0, 8'h11);
    bus.BusGrant = 1'b0;
    step(4'd0, 4'd1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h22);
    chk_status("released", 1'b0, 1'b0, 1'b0);
    rd_reg("a_kept", 4'd1, 8'h5A, 1'b1);
    rd_reg("b_kept", 4'd2, 8'h5A, 1'b1);
    rd_addr("sp_kept", 3'd1, 16'hABFF, 1'b1);
    rd_addr("pc_kept", 3'd0, 16'hABCD, 1'b1);

    // Request and grant together in IDLE still pass through REQ
    bus.BusGrant = 1'b1;
    step(4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk_status("rg_req", 1'b1, 1'b0, 1'b0);
    step(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_status("rg_owned", 1'b1, 1'b1, 1'b0);
    bus.BusGrant = 1'b0;
    step(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_status("rg_idle", 1'b0, 1'b0, 1'b0);

    // Break with increment, then PC frozen while SP keeps working
    step(4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00);
    chk_status("brk", 1'b0, 1'b0, 1'b1);
    rd_addr("brk_pc_inc", 3'd0, 16'hABCE, 1'b1);
    step(4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_addr("halt_pc_frozen", 3'd0, 16'hABCE, 1'b1);
    step(4'd0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_addr("halt_sp_inc", 3'd1, 16'hAC00, 1'b1);

    // Asynchronous reset while OWNED
    step(4'd0, 4'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00);
    bus.BusGrant = 1'b1;
    step(4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk_status("pre_rst_owned", 1'b1, 1'b1, 1'b1);
    Reset_n = 1'b0;
    chk_status("async_rst", 1'b0, 1'b0, 1'b0);
    rd_addr("rst_pc0", 3'd0, 16'h0000, 1'b1);
    rd_addr("rst_sp", 3'd1, 16'h0000, 1'b1);
    rd_addr("rst_si", 3'd2, 16'h0000, 1'b1);
    rd_addr("rst_di", 3'd3, 16'h0000, 1'b1);
    rd_addr("rst_cd", 3'd4, 16'h0000, 1'b1);
    rd_addr("rst_ra", 3'd5, 16'h0000, 1'b1);
    rd_reg("rst_a2", 4'd1, 8'h00, 1'b1);
    rd_reg("rst_b2", 4'd2, 8'h00, 1'b1);
    bus.BusGrant = 1'b0;
    @(negedge ClockIn);
    Reset_n = 1'b1;

    // Halt cleared by reset: PC increments again
    step(4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00);
    rd_addr("post_rst_pc_inc", 3'd0, 16'h0001, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
